z80_bus_responder: RTL and testbench
====================================

# z80_bus_responder

Sound-side Z80 bus responder: the slave end of the Z80 bus driven by the sound CPU core. It decodes every memory and I/O cycle and does four jobs:
- bank-switches M1 ROM fetches to external memory, holding the CPU with nWAIT;
- serves the 68k↔Z80 command and reply latches;
- generates NMI;
- strobes the YM2610 and the 2 KB work RAM.

It sits between the Z80 wrapper and the SDRAM arbiter, YM2610 and RAM.

## Interface
Parameters:
- MEM_AW, 22, external memory byte-address width (4 MB M1 space)

Ports:
- CLK  in  1  system clock
- nRESET  in  1  synchronous active-low reset
- CLK4P_EN  in  1  Z80 clock enable; all bus sampling happens on CLK when CLK4P_EN=1
- SDA  in  16  Z80 address
- SDD_OUT  in  8  Z80 write data
- SDD_IN  out  8  Z80 read data
- nMREQ, nIORQ, nRD, nWR  in  1 each  Z80 strobes (nMREQ already refresh-masked)
- nWAIT  out  1  wait request to Z80
- nNMI  out  1  NMI to Z80
- MEM_REQ  out  1  one-CLK read request pulse
- MEM_ADDR  out  MEM_AW  request address
- MEM_ACK  in  1  one-CLK data-valid pulse
- MEM_DATA  in  8  read data, valid with MEM_ACK
- RAM_CS, RAM_WE  out  1 each  work RAM select/write (combinational)
- RAM_DOUT  in  8  work RAM read data
- YM_CS, YM_WE  out  1 each  YM2610 select/write (combinational)
- YM_A  out  2  YM2610 register address
- YM_DOUT  in  8  YM2610 read data
- CMD_WR  in  1  68k sound-command strobe
- CMD_DATA  in  8  68k sound command
- REPLY  out  8  reply latch to the 68k

## Operation

Memory map (nMREQ low):
- 0000–7FFF: MEM_ADDR = SDA.
- 8000–BFFF: MEM_ADDR = bank3·16K + SDA[13:0].
- C000–DFFF: MEM_ADDR = bank2·8K + SDA[12:0].
- E000–EFFF: MEM_ADDR = bank1·4K + SDA[11:0].
- F000–F7FF: MEM_ADDR = bank0·2K + SDA[10:0].
- F800–FFFF: RAM_CS=1, RAM_WE = ~nWR.
- Banked addresses are truncated to MEM_AW bits. Memory writes to ROM space are ignored.

I/O map (nIORQ low; SDA[7:0] decoded, SDA[4:0] only):
- 00 read: returns the command latch and clears nmi_pend.
- 04–07 read/write: YM_CS=1, YM_A = SDA[1:0], YM_WE = ~nWR.
- 08–0B read: bank0–bank3 ← SDA[15:8]; returns 0xFF.
- 08 write: nmi_en ← 1.
- 0C write: REPLY ← SDD_OUT.
- 18 write: nmi_en ← 0.
- Everything else reads 0xFF and is ignored on write.

SDD_IN mux:
- RAM reads: RAM_DOUT.
- YM reads: YM_DOUT.
- ROM reads: the data register.
- Otherwise: 0xFF.

Command and NMI:
- CMD_WR (any CLK, no enable) loads the command latch.
- If nmi_en=1, CMD_WR also sets nmi_pend.
- nNMI = ~nmi_pend.
- If CMD_WR and a port-00 read clear happen in the same CLK, the set wins.

ROM fetch FSM, states IDLE, REQ, WAIT, DONE:
- IDLE→REQ: on an enabled CLK with nMREQ=0, nRD=0, SDA < F800 and the cycle not yet serviced. nWAIT goes low in that same CLK (combinational from the decode).
- REQ: MEM_REQ=1 for one CLK, MEM_ADDR held; go to WAIT.
- WAIT: on MEM_ACK, data register ← MEM_DATA; go to DONE.
- DONE: nWAIT=1; hold until nRD or nMREQ is high on an enabled CLK, then go to IDLE.
- nWAIT is low only in REQ and WAIT, plus the IDLE-detect CLK.
- MEM_ACK outside WAIT is ignored.

## Timing
- Reset values:
  - SDD_IN=FF, nWAIT=1, nNMI=1, MEM_REQ=0, MEM_ADDR=0, REPLY=00.
  - command latch=00, data register=FF, nmi_en=0, nmi_pend=0.
  - bank0=1E, bank1=0E, bank2=06, bank3=02 (linear identity map).
  - FSM state = IDLE.
- Reset mid-fetch: FSM returns to IDLE and any later stray MEM_ACK is dropped.
- I/O register writes and bank loads take effect on the enabled CLK where the strobe is first seen low. Each bus cycle commits exactly once, tracked by a "serviced" flag cleared when both nRD and nWR are high.
- Minimum ROM latency: detect → REQ → WAIT+ACK → DONE gives data 2 CLK after detect, plus memory latency.
- nIORQ low with nRD=nWR=1 (interrupt acknowledge) is ignored; SDD_IN=FF.

## Structure
- Shared package `z80_io_pkg` holds:
  - port numbers (P_CMD=00, P_YM=04, P_BANK=08, P_NMI_EN=08, P_REPLY=0C, P_NMI_DIS=18);
  - bank reset constants;
  - fetch FSM state enum.
- One natural sub-module: `z80_rom_fetch`, containing the FSM, the data register and MEM_REQ/nWAIT generation. Decode and latches stay in the top module.

## Test plan
- Reset, then Z80 reads 0x8123, MEM_ACK with 5A after 3 CLK → MEM_ADDR=0x08123, nWAIT low until ACK, SDD_IN=5A.
- IN port 0x0B with SDA=0x200B, then read 0x8010 → MEM_ADDR = 0x20·16K + 0x10 = 0x080010.
- Write port 08, CMD_WR with 0x33 → nNMI=0. IN port 00 returns 33 and nNMI=1. After OUT port 18, a further CMD_WR leaves nNMI=1.
- OUT port 0C with 0xA5 → REPLY=A5. Write to 0xF900 → RAM_CS=1, RAM_WE=1. Read port 05 → YM_CS=1, YM_A=1, SDD_IN=YM_DOUT.
- nRESET asserted during WAIT, then MEM_ACK arrives → ignored; next fetch completes normally; banks back at reset values.
- CMD_WR coincident with a port-00 read while nmi_en=1 → nmi_pend stays set, nNMI=0.

Source files
------------

// File: rtl/z80_io_pkg.sv
// z80_io_pkg: constants shared by the sound-side Z80 bus responder.
// Holds the I/O port numbers (only SDA[4:0] is decoded), the reset bank
// values that make the banked windows an identity map, and the ROM fetch
// FSM state encoding.
package z80_io_pkg;

    // I/O ports, compared against SDA[4:0]
    localparam logic [4:0] P_CMD     = 5'h00;
    localparam logic [4:0] P_YM      = 5'h04;  // 04..07
    localparam logic [4:0] P_BANK    = 5'h08;  // 08..0B, reads only
    localparam logic [4:0] P_NMI_EN  = 5'h08;  // write
    localparam logic [4:0] P_REPLY   = 5'h0C;
    localparam logic [4:0] P_NMI_DIS = 5'h18;

    // bank3..bank0; with these the 8000-F7FF windows map onto themselves
    localparam logic [3:0][7:0] BANK_RST = {8'h02, 8'h06, 8'h0E, 8'h1E};

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_WAIT = 2'd2,
        F_DONE = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/z80_rom_fetch.sv
// z80_rom_fetch: ROM fetch sequencer for the Z80 bus responder.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   en_i               Z80 clock enable
//   start_i            decoded, not-yet-serviced ROM read on an enabled CLK
//   cycle_end_i        nRD or nMREQ high (Z80 has finished the read)
//   addr_i             translated external address, captured on start_i
//   mem_ack_i/data_i   memory return path
//   mem_req_o/addr_o   memory request path
//   data_o             data register presented to the Z80
//   nwait_o            wait request to the Z80
//   state_o            current FSM state (debug visibility)
//
// Memory handshake: mem_req_o is a single-CLK pulse with mem_addr_o held
// stable; the memory answers later with a single-CLK mem_ack_i carrying
// mem_data_i. Only one request is ever outstanding, and an ack that does
// not arrive in F_WAIT (e.g. after a reset mid-fetch) is discarded.
module z80_rom_fetch
    import z80_io_pkg::*;
#(
    parameter int MEM_AW = 22
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              start_i,
    input  logic              cycle_end_i,
    input  logic [MEM_AW-1:0] addr_i,
    input  logic              mem_ack_i,
    input  logic [7:0]        mem_data_i,
    output logic              mem_req_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [7:0]        data_o,
    output logic              nwait_o,
    output fetch_state_t      state_o
);

    fetch_state_t      state_q, state_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= F_IDLE;
            addr_q  <= '0;
            data_q  <= 8'hFF;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            F_IDLE: begin
                if (start_i) begin
                    state_d = F_REQ;
                    addr_d  = addr_i;
                end
            end
            F_REQ:  state_d = F_WAIT;
            F_WAIT: begin
                if (mem_ack_i) begin
                    data_d  = mem_data_i;
                    state_d = F_DONE;
                end
            end
            F_DONE: begin
                if (en_i && cycle_end_i) state_d = F_IDLE;
            end
            default: state_d = F_IDLE;
        endcase
    end

    assign mem_req_o  = (state_q == F_REQ);
    assign mem_addr_o = addr_q;
    assign data_o     = data_q;
    // Wait must already be low in the detect CLK so the Z80 samples it
    // before the fetch has even been issued.
    assign nwait_o    = !((state_q == F_REQ) || (state_q == F_WAIT) ||
                          ((state_q == F_IDLE) && start_i));
    assign state_o    = state_q;

endmodule

// File: rtl/z80_bus_responder.sv
// z80_bus_responder: slave end of the sound Z80 bus.
// Decodes memory and I/O cycles: banked ROM fetches to external memory
// (via z80_rom_fetch), 2 KB work RAM and YM2610 strobes, the 68k command
// and reply latches, bank registers and NMI generation.
// Ports:
//   CLK, nRESET, CLK4P_EN          clock, sync active-low reset, Z80 enable
//   SDA, SDD_OUT, SDD_IN           Z80 address, write data, read data
//   nMREQ, nIORQ, nRD, nWR         Z80 strobes
//   nWAIT, nNMI                    wait request, NMI
//   MEM_REQ, MEM_ADDR, MEM_ACK,
//   MEM_DATA                       external ROM read path
//   RAM_CS, RAM_WE, RAM_DOUT       work RAM
//   YM_CS, YM_WE, YM_A, YM_DOUT    YM2610
//   CMD_WR, CMD_DATA, REPLY        68k command in, reply out
module z80_bus_responder
    import z80_io_pkg::*;
#(
    parameter int MEM_AW = 22
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              CLK4P_EN,
    input  logic [15:0]       SDA,
    input  logic [7:0]        SDD_OUT,
    output logic [7:0]        SDD_IN,
    input  logic              nMREQ,
    input  logic              nIORQ,
    input  logic              nRD,
    input  logic              nWR,
    output logic              nWAIT,
    output logic              nNMI,
    output logic              MEM_REQ,
    output logic [MEM_AW-1:0] MEM_ADDR,
    input  logic              MEM_ACK,
    input  logic [7:0]        MEM_DATA,
    output logic              RAM_CS,
    output logic              RAM_WE,
    input  logic [7:0]        RAM_DOUT,
    output logic              YM_CS,
    output logic              YM_WE,
    output logic [1:0]        YM_A,
    input  logic [7:0]        YM_DOUT,
    input  logic              CMD_WR,
    input  logic [7:0]        CMD_DATA,
    output logic [7:0]        REPLY
);

    logic [7:0]       cmd_q, cmd_d;
    logic [7:0]       reply_q, reply_d;
    logic [3:0][7:0]  bank_q, bank_d;
    logic             nmi_en_q, nmi_en_d;
    logic             nmi_pend_q, nmi_pend_d;
    logic             serviced_q, serviced_d;

    logic              mem_cyc, io_cyc, rd_act, wr_act;
    logic              ram_sel, rom_rd, ym_sel;
    logic [4:0]        port;
    logic              commit, rom_start, io_rd_commit, io_wr_commit;
    logic [MEM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;
    fetch_state_t      fetch_state;

    // ---------------- decode ----------------
    always_comb begin
        mem_cyc = !nMREQ;
        io_cyc  = !nIORQ;
        rd_act  = !nRD;
        wr_act  = !nWR;
        port    = SDA[4:0];
        ram_sel = mem_cyc && (SDA[15:11] == 5'b11111);
        rom_rd  = mem_cyc && !ram_sel && rd_act;
        // interrupt acknowledge (nIORQ low, no rd/wr) selects nothing
        ym_sel  = io_cyc && (rd_act || wr_act) && (port[4:2] == P_YM[4:2]);

        // A bus cycle commits once, on its first enabled CLK. A ROM read is
        // held off until the fetcher is idle so it is never silently lost.
        commit       = CLK4P_EN && !serviced_q && (rd_act || wr_act) &&
                       (mem_cyc || io_cyc) &&
                       !(rom_rd && (fetch_state != F_IDLE));
        rom_start    = commit && rom_rd;
        io_rd_commit = commit && io_cyc && rd_act;
        io_wr_commit = commit && io_cyc && wr_act;

        // Banked windows; the shifts truncate to MEM_AW bits.
        if (!SDA[15])
            rom_addr = MEM_AW'(SDA);
        else if (SDA[15:14] == 2'b10)
            rom_addr = (MEM_AW'(bank_q[3]) << 14) | MEM_AW'(SDA[13:0]);
        else if (SDA[15:13] == 3'b110)
            rom_addr = (MEM_AW'(bank_q[2]) << 13) | MEM_AW'(SDA[12:0]);
        else if (SDA[15:12] == 4'b1110)
            rom_addr = (MEM_AW'(bank_q[1]) << 12) | MEM_AW'(SDA[11:0]);
        else
            rom_addr = (MEM_AW'(bank_q[0]) << 11) | MEM_AW'(SDA[10:0]);
    end

    // ---------------- latches and registers ----------------
    always_comb begin
        cmd_d      = cmd_q;
        reply_d    = reply_q;
        bank_d     = bank_q;
        nmi_en_d   = nmi_en_q;
        nmi_pend_d = nmi_pend_q;
        serviced_d = serviced_q;

        if (CMD_WR) cmd_d = CMD_DATA;

        if (io_wr_commit) begin
            if (port == P_NMI_EN)  nmi_en_d = 1'b1;
            if (port == P_NMI_DIS) nmi_en_d = 1'b0;
            if (port == P_REPLY)   reply_d  = SDD_OUT;
        end

        // Bank number comes from the upper address byte of the IN cycle.
        if (io_rd_commit && (port[4:2] == P_BANK[4:2]))
            bank_d[port[1:0]] = SDA[15:8];

        // Clear first, then set, so a coincident CMD_WR wins.
        if (io_rd_commit && (port == P_CMD)) nmi_pend_d = 1'b0;
        if (CMD_WR && nmi_en_q)              nmi_pend_d = 1'b1;

        if (CLK4P_EN) begin
            if (nRD && nWR)  serviced_d = 1'b0;
            else if (commit) serviced_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            cmd_q      <= 8'h00;
            reply_q    <= 8'h00;
            bank_q     <= BANK_RST;
            nmi_en_q   <= 1'b0;
            nmi_pend_q <= 1'b0;
            serviced_q <= 1'b0;
        end else begin
            cmd_q      <= cmd_d;
            reply_q    <= reply_d;
            bank_q     <= bank_d;
            nmi_en_q   <= nmi_en_d;
            nmi_pend_q <= nmi_pend_d;
            serviced_q <= serviced_d;
        end
    end

    // ---------------- ROM fetch ----------------
    z80_rom_fetch #(.MEM_AW(MEM_AW)) u_fetch (
        .clk_i       (CLK),
        .rst_ni      (nRESET),
        .en_i        (CLK4P_EN),
        .start_i     (rom_start),
        .cycle_end_i (nRD || nMREQ),
        .addr_i      (rom_addr),
        .mem_ack_i   (MEM_ACK),
        .mem_data_i  (MEM_DATA),
        .mem_req_o   (MEM_REQ),
        .mem_addr_o  (MEM_ADDR),
        .data_o      (rom_data),
        .nwait_o     (nWAIT),
        .state_o     (fetch_state)
    );

    // ---------------- outputs ----------------
    always_comb begin
        SDD_IN = 8'hFF;
        if (mem_cyc && rd_act) begin
            SDD_IN = ram_sel ? RAM_DOUT : rom_data;
        end else if (io_cyc && rd_act) begin
            if (ym_sel)              SDD_IN = YM_DOUT;
            else if (port == P_CMD)  SDD_IN = cmd_q;
        end
    end

    assign RAM_CS = ram_sel;
    assign RAM_WE = ram_sel && wr_act;
    assign YM_CS  = ym_sel;
    assign YM_WE  = ym_sel && wr_act;
    assign YM_A   = SDA[1:0];
    assign nNMI   = !nmi_pend_q;
    assign REPLY  = reply_q;

endmodule

// File: tb/tb_z80_bus_responder.sv
// Testbench for z80_bus_responder: directed steps plus randomized bank
// loads, ROM fetches and RAM reads, checked against a behavioural model of
// the memory map, bank registers, command/reply latches and NMI state.
module tb_z80_bus_responder;

    // ---------------- clock / reset ----------------
    logic        CLK = 1'b0;
    logic        nRESET = 1'b0;
    logic        CLK4P_EN = 1'b1;
    logic [15:0] SDA = 16'h0000;
    logic [7:0]  SDD_OUT = 8'h00;
    logic [7:0]  SDD_IN;
    logic        nMREQ = 1'b1, nIORQ = 1'b1, nRD = 1'b1, nWR = 1'b1;
    logic        nWAIT, nNMI, MEM_REQ;
    logic [21:0] MEM_ADDR;
    logic        MEM_ACK = 1'b0;
    logic [7:0]  MEM_DATA = 8'h00;
    logic        RAM_CS, RAM_WE, YM_CS, YM_WE;
    logic [1:0]  YM_A;
    logic [7:0]  RAM_DOUT = 8'h00, YM_DOUT = 8'h00;
    logic        CMD_WR = 1'b0;
    logic [7:0]  CMD_DATA = 8'h00;
    logic [7:0]  REPLY;

    always #5 CLK = ~CLK;

    z80_bus_responder #(.MEM_AW(22)) dut (
        .CLK(CLK), .nRESET(nRESET), .CLK4P_EN(CLK4P_EN),
        .SDA(SDA), .SDD_OUT(SDD_OUT), .SDD_IN(SDD_IN),
        .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR),
        .nWAIT(nWAIT), .nNMI(nNMI),
        .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK), .MEM_DATA(MEM_DATA),
        .RAM_CS(RAM_CS), .RAM_WE(RAM_WE), .RAM_DOUT(RAM_DOUT),
        .YM_CS(YM_CS), .YM_WE(YM_WE), .YM_A(YM_A), .YM_DOUT(YM_DOUT),
        .CMD_WR(CMD_WR), .CMD_DATA(CMD_DATA), .REPLY(REPLY)
    );

    // ---------------- reference model ----------------
    int         n_vec = 0;
    int         n_err = 0;
    int         m_bank [4];
    logic [7:0] m_cmd, m_reply;
    bit         m_nmi_en, m_pend;

    function automatic void model_reset();
        m_bank[0] = 'h1E; m_bank[1] = 'h0E; m_bank[2] = 'h06; m_bank[3] = 'h02;
        m_cmd = 8'h00; m_reply = 8'h00; m_nmi_en = 0; m_pend = 0;
    endfunction

    // External address of a ROM-space Z80 address, from the window sizes.
    function automatic int exp_addr(input int a);
        int r;
        if (a < 'h8000)      r = a;
        else if (a < 'hC000) r = m_bank[3] * 16384 + (a - 'h8000);
        else if (a < 'hE000) r = m_bank[2] * 8192  + (a - 'hC000);
        else if (a < 'hF000) r = m_bank[1] * 4096  + (a - 'hE000);
        else                 r = m_bank[0] * 2048  + (a - 'hF000);
        return r % (1 << 22);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic rom_read(input int a, input int lat, input logic [7:0] d);
        int ea;
        ea = exp_addr(a);
        @(negedge CLK); SDA = 16'(a); nMREQ = 1'b0; nRD = 1'b0; #1;
        check("rom_detect_nwait", 32'(nWAIT), 32'd0);
        @(negedge CLK);
        check("rom_req", 32'(MEM_REQ), 32'd1);
        check("rom_addr", 32'(MEM_ADDR), 32'(ea));
        for (int i = 1; i < lat; i++) begin
            @(negedge CLK);
            check("rom_wait_nwait", 32'(nWAIT), 32'd0);
        end
        @(negedge CLK);
        check("rom_req_single", 32'(MEM_REQ), 32'd0);
        check("rom_ack_nwait", 32'(nWAIT), 32'd0);
        MEM_ACK = 1'b1; MEM_DATA = d;
        @(negedge CLK); MEM_ACK = 1'b0; MEM_DATA = 8'($urandom); #1;
        check("rom_done_nwait", 32'(nWAIT), 32'd1);
        check("rom_data", 32'(SDD_IN), 32'(d));
        @(negedge CLK); nMREQ = 1'b1; nRD = 1'b1;
        @(negedge CLK);
    endtask

    task automatic io_read(input int a, output logic [7:0] d);
        @(negedge CLK); SDA = 16'(a); nIORQ = 1'b0; nRD = 1'b0; #1;
        d = SDD_IN;
        @(negedge CLK); nIORQ = 1'b1; nRD = 1'b1;
        @(negedge CLK);
    endtask

    task automatic io_write(input int a, input logic [7:0] v);
        @(negedge CLK); SDA = 16'(a); SDD_OUT = v; nIORQ = 1'b0; nWR = 1'b0;
        @(negedge CLK); nIORQ = 1'b1; nWR = 1'b1;
        @(negedge CLK);
    endtask

    task automatic cmd_write(input logic [7:0] v);
        @(negedge CLK); CMD_WR = 1'b1; CMD_DATA = v;
        @(negedge CLK); CMD_WR = 1'b0;
        m_cmd = v;
        if (m_nmi_en) m_pend = 1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] rd;
        int a, p, hi;

        model_reset();
        repeat (3) @(negedge CLK);
        #1;
        check("rst_sdd_in", 32'(SDD_IN), 32'hFF);
        check("rst_nwait", 32'(nWAIT), 32'd1);
        check("rst_nnmi", 32'(nNMI), 32'd1);
        check("rst_mem_req", 32'(MEM_REQ), 32'd0);
        check("rst_mem_addr", 32'(MEM_ADDR), 32'd0);
        check("rst_reply", 32'(REPLY), 32'h00);
        nRESET = 1'b1;
        io_read('h0000, rd);
        check("rst_cmd_latch", 32'(rd), 32'(m_cmd));

        // identity-mapped banked fetch
        rom_read('h8123, 3, 8'h5A);

        // bank3 load through the address high byte
        io_read('h200B, rd);
        check("bank_read_ff", 32'(rd), 32'hFF);
        m_bank[3] = 'h20;
        rom_read('h8010, 1, 8'($urandom));

        // NMI enable, command, clear by port 00, disable
        io_write('h0008, 8'h00); m_nmi_en = 1;
        cmd_write(8'h33); #1;
        check("nmi_set", 32'(nNMI), 32'(!m_pend));
        io_read('h0000, rd); m_pend = 0;
        check("cmd_read", 32'(rd), 32'h33);
        check("nmi_cleared", 32'(nNMI), 32'(!m_pend));
        io_write('h0018, 8'h00); m_nmi_en = 0;
        cmd_write(8'h44); #1;
        check("nmi_disabled", 32'(nNMI), 32'(!m_pend));

        // reply latch, RAM write, YM read
        io_write('h000C, 8'hA5); m_reply = 8'hA5;
        check("reply", 32'(REPLY), 32'(m_reply));
        @(negedge CLK); SDA = 16'hF900; nMREQ = 1'b0; nWR = 1'b0; #1;
        check("ram_wr_cs", 32'(RAM_CS), 32'd1);
        check("ram_wr_we", 32'(RAM_WE), 32'd1);
        check("ram_wr_nwait", 32'(nWAIT), 32'd1);
        @(negedge CLK); nMREQ = 1'b1; nWR = 1'b1;
        @(negedge CLK); SDA = 16'h0005; YM_DOUT = 8'h9C; nIORQ = 1'b0; nRD = 1'b0; #1;
        check("ym_cs", 32'(YM_CS), 32'd1);
        check("ym_a", 32'(YM_A), 32'd1);
        check("ym_we", 32'(YM_WE), 32'd0);
        check("ym_data", 32'(SDD_IN), 32'h9C);
        @(negedge CLK); nIORQ = 1'b1; nRD = 1'b1;

        // CMD_WR in the same CLK as the port-00 clear: set wins
        io_write('h0008, 8'h00); m_nmi_en = 1;
        cmd_write(8'h11);
        @(negedge CLK); SDA = 16'h0000; nIORQ = 1'b0; nRD = 1'b0;
        CMD_WR = 1'b1; CMD_DATA = 8'h77; #1;
        check("coinc_read", 32'(SDD_IN), 32'h11);
        @(negedge CLK); CMD_WR = 1'b0; nIORQ = 1'b1; nRD = 1'b1; #1;
        m_cmd = 8'h77; m_pend = 1;
        check("coinc_set_wins", 32'(nNMI), 32'(!m_pend));

        // held port-00 read clears only on its first CLK
        @(negedge CLK); SDA = 16'h0000; nIORQ = 1'b0; nRD = 1'b0; #1;
        check("held_read", 32'(SDD_IN), 32'(m_cmd));
        @(negedge CLK); m_pend = 0;
        check("held_first_clear", 32'(nNMI), 32'(!m_pend));
        CMD_WR = 1'b1; CMD_DATA = 8'h66;
        @(negedge CLK); CMD_WR = 1'b0; m_cmd = 8'h66; m_pend = 1;
        @(negedge CLK);
        check("held_commit_once", 32'(nNMI), 32'(!m_pend));
        nIORQ = 1'b1; nRD = 1'b1;
        @(negedge CLK);
        io_read('h0000, rd); m_pend = 0;
        check("cmd_read2", 32'(rd), 32'(m_cmd));
        check("nmi_cleared2", 32'(nNMI), 32'(!m_pend));

        // ROM-space write ignored; interrupt acknowledge ignored
        @(negedge CLK); SDA = 16'h1234; nMREQ = 1'b0; nWR = 1'b0; #1;
        check("romwr_nwait", 32'(nWAIT), 32'd1);
        @(negedge CLK);
        check("romwr_no_req", 32'(MEM_REQ), 32'd0);
        nMREQ = 1'b1; nWR = 1'b1;
        @(negedge CLK); SDA = 16'h0005; nIORQ = 1'b0; #1;
        check("intack_ym_cs", 32'(YM_CS), 32'd0);
        check("intack_sdd", 32'(SDD_IN), 32'hFF);
        @(negedge CLK); nIORQ = 1'b1;

        // randomized bank loads, ROM fetches, RAM reads
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    p  = $urandom_range(8, 11);
                    hi = $urandom_range(0, 255);
                    io_read((hi << 8) | ($urandom_range(0, 7) << 5) | p, rd);
                    m_bank[p - 8] = hi;
                    check("rnd_bank_ff", 32'(rd), 32'hFF);
                end
                1: begin
                    a = $urandom_range(0, 'hF7FF);
                    rom_read(a, $urandom_range(1, 4), 8'($urandom));
                end
                default: begin
                    a  = $urandom_range('hF800, 'hFFFF);
                    rd = 8'($urandom);
                    @(negedge CLK); SDA = 16'(a); RAM_DOUT = rd; nMREQ = 1'b0; nRD = 1'b0; #1;
                    check("rnd_ram_cs", 32'(RAM_CS), 32'd1);
                    check("rnd_ram_we", 32'(RAM_WE), 32'd0);
                    check("rnd_ram_data", 32'(SDD_IN), 32'(rd));
                    @(negedge CLK); nMREQ = 1'b1; nRD = 1'b1;
                    @(negedge CLK);
                end
            endcase
        end

        // reset in the middle of a fetch; late ack must be dropped
        cmd_write(8'h55);
        @(negedge CLK); SDA = 16'hA000; nMREQ = 1'b0; nRD = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("pre_reset_wait", 32'(nWAIT), 32'd0);
        nRESET = 1'b0; nMREQ = 1'b1; nRD = 1'b1;
        @(negedge CLK);
        @(negedge CLK); nRESET = 1'b1; model_reset();
        @(negedge CLK); MEM_ACK = 1'b1; MEM_DATA = 8'hEE;
        @(negedge CLK); MEM_ACK = 1'b0; #1;
        check("stray_ack_nwait", 32'(nWAIT), 32'd1);
        check("stray_ack_req", 32'(MEM_REQ), 32'd0);
        check("post_rst_reply", 32'(REPLY), 32'(m_reply));
        check("post_rst_nnmi", 32'(nNMI), 32'(!m_pend));
        rom_read('h9000, 2, 8'h3C);
        rom_read('hF123, 1, 8'hC3);
        rom_read('hD456, 2, 8'h18);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
